e_hilo_md_unit: RTL and testbench
=================================

// Module: e_hilo_md_unit
// PURPOSE
// - E-stage multiply/divide unit owning the HI/LO registers; producer of the HI/LO word that the M stage
//   carries as M_HL_data into its GRF write-data select (HL source).
// - Accepts mult/multu/div/divu/mthi/mtlo from E, models multi-cycle latency with a busy counter,
//   and drives busy/start so the hazard unit can stall md instructions in D.
// PARAMETERS
// - MULT_CYCLES  5   busy cycles after a mult/multu (and madd-family) issue, >=1
// - DIV_CYCLES   10  busy cycles after a div/divu issue, >=1
// PORTS
// - clk        in   1   rising-edge clock
// - reset      in   1   asynchronous, active-low reset (0 = reset)
// - E_rs_data  in   32  forwarded rs operand
// - E_rt_data  in   32  forwarded rt operand
// - E_md_op    in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo,9-12 see CONFIGURATION
// - E_start    out  1   combinational: high in the cycle a mult/div-class op is accepted
// - E_busy     out  1   registered: high while a mult/div result is pending
// - E_HL_data  out  32  mfhi ? HI : mflo ? LO : 32'd0 (combinational from the HI/LO registers)
// BEHAVIOUR
// - Reset (reset==0, async): HI=0, LO=0, count=0, E_busy=0, pending regs=0; E_start follows its equation.
// - Accept: mult-class op accepted iff E_md_op is mult-class and E_busy==0 -> E_start=1.
//   Ops arriving while E_busy==1 (incl. mthi/mtlo) are ignored; hazard unit is required to prevent this.
// - States: IDLE (count==0) / BUSY (count>0).
//   IDLE + accepted mult/madd-class -> count=MULT_CYCLES, E_busy=1, result latched into pend_hi/pend_lo.
//   IDLE + accepted div/divu -> count=DIV_CYCLES, same latching.
//   BUSY: count decrements each edge; on the edge where count goes 1->0, HI<=pend_hi, LO<=pend_lo, E_busy<=0.
//   Next md op accepted in the first cycle E_busy reads 0 (no bubble beyond the latency).
// - mthi/mtlo in IDLE: HI<=E_rs_data or LO<=E_rs_data at next edge, no busy.
// - mfhi/mflo: E_HL_data shows committed HI/LO; while BUSY it shows old values (stall enforces correctness).
// - Arithmetic: mult signed 32x32->64, multu unsigned; {pend_hi,pend_lo}=product.
//   div: LO=quotient truncated toward zero, HI=remainder with sign of dividend; divu unsigned.
//   0x80000000 div 0xFFFFFFFF -> LO=0x80000000, HI=0 (wrap, no trap).
//   Divisor==0: busy sequence runs normally; at commit HI and LO keep their previous values.
// - Reset mid-operation: pending result discarded, busy cleared immediately, HI/LO=0.
// - Opcodes 9-12 without the macro, and 13-15 always: no-op, E_start=0, E_HL_data=0.
// CONFIGURATION
// - MD_MADD_EN defined: 9 madd,10 maddu,11 msub,12 msubu are mult-class (MULT_CYCLES latency);
//   pend = {HI,LO} +/- product (signed or unsigned per op), 64-bit wrap, using HI/LO at accept time.
// - MD_MADD_EN undefined: 9-12 decode as no-op; no accumulate datapath is synthesised.
// TESTING
// - reset low mid-run -> E_busy=0, HI=LO=0 asynchronously; E_HL_data=0 for mfhi and mflo.
// - mult rs=0xFFFFFFFF rt=2 -> E_start=1 one cycle, E_busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE;
//   multu same operands -> HI=1 LO=0xFFFFFFFE.
// - div rs=-7 rt=2 -> E_busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu 7/2 -> LO=3 HI=1.
// - div rt=0 after mtlo 0x1234, mthi 0x5678 -> after 10 busy cycles LO=0x1234 HI=0x5678 unchanged.
// - mult issued, then mtlo 0xAAAA presented during busy -> ignored, E_start=0; LO=product at commit;
//   mflo in first cycle after commit -> E_HL_data=product low word.
// - MD_MADD_EN: HI=0 LO=0xFFFFFFFF, maddu rs=1 rt=1 -> after 5 cycles HI=1 LO=0;
//   without macro op 9 -> E_start=0, HI/LO unchanged.

Source files
------------

// File: rtl/e_hilo_md_if.sv
// E-stage multiply/divide bus: operands and opcode in, start/busy/HL word out.
interface e_hilo_md_if;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic [3:0]  E_md_op;
    logic        E_start;
    logic        E_busy;
    logic [31:0] E_HL_data;

    modport master (
        output E_rs_data, E_rt_data, E_md_op,
        input  E_start, E_busy, E_HL_data
    );

    modport slave (
        input  E_rs_data, E_rt_data, E_md_op,
        output E_start, E_busy, E_HL_data
    );
endinterface

// File: rtl/e_hilo_md_unit.sv
// E-stage mult/div unit owning HI/LO with a busy-counter latency model.
// Optional MD_MADD_EN adds madd/maddu/msub/msubu (ops 9-12) as mult-class.
module e_hilo_md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    e_hilo_md_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_count;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_pend_hi;
    logic [31:0]   r_pend_lo;
    logic          r_pend_keep;

    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_mul;
    logic        w_mulu;
    logic        w_div;
    logic        w_divu;
    logic        w_acc_cls;
    logic        w_mul_cls;
    logic        w_start;
    logic        w_b0;

    assign w_op   = bus.E_md_op;
    assign w_a    = bus.E_rs_data;
    assign w_b    = bus.E_rt_data;
    assign w_mul  = (w_op == 4'd1);
    assign w_mulu = (w_op == 4'd2);
    assign w_div  = (w_op == 4'd3);
    assign w_divu = (w_op == 4'd4);
    assign w_b0   = (w_b == 32'd0);

`ifdef MD_MADD_EN
    logic        w_madd;
    logic        w_maddu;
    logic        w_msub;
    logic        w_msubu;
    logic [63:0] w_acc;
    assign w_madd    = (w_op == 4'd9);
    assign w_maddu   = (w_op == 4'd10);
    assign w_msub    = (w_op == 4'd11);
    assign w_msubu   = (w_op == 4'd12);
    assign w_acc     = {r_hi, r_lo};
    assign w_acc_cls = w_madd | w_maddu | w_msub | w_msubu;
`else
    assign w_acc_cls = 1'b0;
`endif

    assign w_mul_cls = w_mul | w_mulu | w_acc_cls;
    assign w_start   = (w_mul_cls | w_div | w_divu) & (r_state == S_IDLE);

    // Signed product from sign-extended operands; low 64 bits are exact.
    logic [63:0] w_sa;
    logic [63:0] w_sb;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_sa     = {{32{w_a[31]}}, w_a};
    assign w_sb     = {{32{w_b[31]}}, w_b};
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};

    // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly.
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_ubd;
    logic [31:0] w_bd;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    assign w_ua    = w_a[31] ? (32'd0 - w_a) : w_a;
    assign w_ub    = w_b[31] ? (32'd0 - w_b) : w_b;
    assign w_ubd   = w_b0 ? 32'd1 : w_ub;
    assign w_bd    = w_b0 ? 32'd1 : w_b;
    assign w_uq    = w_ua / w_ubd;
    assign w_ur    = w_ua % w_ubd;
    assign w_quo_s = (w_a[31] ^ w_b[31]) ? (32'd0 - w_uq) : w_uq;
    assign w_rem_s = w_a[31] ? (32'd0 - w_ur) : w_ur;

    logic [63:0] w_pend;
    logic        w_keep;

    always_comb begin
        w_pend = 64'd0;
        w_keep = 1'b0;
        unique case (1'b1)
            w_mul:  w_pend = w_prod_s;
            w_mulu: w_pend = w_prod_u;
            w_div: begin
                w_pend = {w_rem_s, w_quo_s};
                w_keep = w_b0;
            end
            w_divu: begin
                w_pend = {w_a % w_bd, w_a / w_bd};
                w_keep = w_b0;
            end
`ifdef MD_MADD_EN
            w_madd:  w_pend = w_acc + w_prod_s;
            w_maddu: w_pend = w_acc + w_prod_u;
            w_msub:  w_pend = w_acc - w_prod_s;
            w_msubu: w_pend = w_acc - w_prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_keep <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_BUSY;
                        r_count     <= w_mul_cls ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        r_pend_hi   <= w_pend[63:32];
                        r_pend_lo   <= w_pend[31:0];
                        r_pend_keep <= w_keep;
                    end else if (w_op == 4'd5) begin
                        r_hi <= w_a;
                    end else if (w_op == 4'd6) begin
                        r_lo <= w_a;
                    end
                end
                default: begin
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= S_IDLE;
                        if (!r_pend_keep) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.E_start   = w_start;
    assign bus.E_busy    = (r_state == S_BUSY);
    assign bus.E_HL_data = (w_op == 4'd7) ? r_hi :
                           (w_op == 4'd8) ? r_lo : 32'd0;
endmodule

// File: tb/tb_e_hilo_md_unit.sv
// Randomized self-checking bench for e_hilo_md_unit against a HI/LO model.
// Build with +define+MD_MADD_EN to exercise the accumulate ops.
module tb_e_hilo_md_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_hilo_md_if bus ();

    e_hilo_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic bit is_md(input logic [3:0] op);
`ifdef MD_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic int lat(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? 10 : 5;
    endfunction

    // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sp = sa * sb;
        up = ua * ub;
        acc = {m_hi, m_lo};
        case (op)
            4'd1: {m_hi, m_lo} = sp;
            4'd2: {m_hi, m_lo} = up;
            4'd3: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            4'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            4'd5: m_hi = a;
            4'd6: m_lo = a;
`ifdef MD_MADD_EN
            4'd9:  {m_hi, m_lo} = acc + longint'(sp);
            4'd10: {m_hi, m_lo} = acc + up;
            4'd11: {m_hi, m_lo} = acc - longint'(sp);
            4'd12: {m_hi, m_lo} = acc - up;
`endif
            default: ;
        endcase
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic st);
        @(negedge clk);
        bus.E_md_op = op;
        bus.E_rs_data = a;
        bus.E_rt_data = b;
        #1 st = bus.E_start;
        @(posedge clk);
        #1 bus.E_md_op = 4'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.E_busy !== 1'b0 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        bus.E_md_op = 4'd7;
        #1 hi = bus.E_HL_data;
        bus.E_md_op = 4'd8;
        #1 lo = bus.E_HL_data;
        bus.E_md_op = 4'd0;
    endtask

    task automatic test_reset;
        bus.E_md_op = 4'd1;
        bus.E_rs_data = 32'd3;
        bus.E_rt_data = 32'd4;
        #2;
        n_total++;
        if (bus.E_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got=%b exp=0", bus.E_busy);
        end
        n_total++;
        if (bus.E_start !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_start got=%b exp=1", bus.E_start);
        end
        bus.E_md_op = 4'd7;
        #1;
        n_total++;
        if (bus.E_HL_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_hi got=%h exp=0", bus.E_HL_data);
        end
        bus.E_md_op = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_op(input string nm, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic st;
        int n;
        logic [31:0] hi, lo;
        bit md;
        md = is_md(op);
        issue(op, a, b, st);
        model(op, a, b);
        n_total++;
        if (st !== md) begin
            n_bad++;
            $display("FAIL %s_start op=%0d got=%b exp=%b", nm, op, st, md);
        end
        wait_idle(n);
        if (md) begin
            n_total++;
            if (n != lat(op)) begin
                n_bad++;
                $display("FAIL %s_busy op=%0d got=%0d exp=%0d", nm, op, n, lat(op));
            end
        end
        read_hl(hi, lo);
        n_total++;
        if (hi !== m_hi || lo !== m_lo) begin
            n_bad++;
            $display("FAIL %s_hilo op=%0d got=%h_%h exp=%h_%h", nm, op, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_vectors;
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2);
        n_total++;
        if (m_hi !== 32'hFFFF_FFFF || m_lo !== 32'hFFFF_FFFE) begin
            n_bad++;
            $display("FAIL mult_model got=%h_%h exp=ffffffff_fffffffe", m_hi, m_lo);
        end
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 4'd4, 32'd7, 32'd2);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mtlo", 4'd6, 32'h1234, 32'd0);
        run_op("mthi", 4'd5, 32'h5678, 32'd0);
        run_op("divz", 4'd3, 32'd99, 32'd0);
        run_op("divuz", 4'd4, 32'd99, 32'd0);
    endtask

    task automatic test_busy_ignore;
        logic st;
        int n;
        logic [31:0] got;
        issue(4'd1, 32'd3, 32'd5, st);
        model(4'd1, 32'd3, 32'd5);
        issue(4'd6, 32'hAAAA, 32'd0, st);
        n_total++;
        if (st !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_mtlo_start got=%b exp=0", st);
        end
        issue(4'd2, 32'd9, 32'd9, st);
        n_total++;
        if (st !== 1'b0) begin
            n_bad++;
            $display("FAIL ign_mult_start got=%b exp=0", st);
        end
        wait_idle(n);
        n_total++;
        if (n != 3) begin
            n_bad++;
            $display("FAIL ign_busy_left got=%0d exp=3", n);
        end
        bus.E_md_op = 4'd8;
        #1 got = bus.E_HL_data;
        bus.E_md_op = 4'd0;
        n_total++;
        if (got !== 32'd15) begin
            n_bad++;
            $display("FAIL ign_mflo got=%h exp=0000000f", got);
        end
    endtask

    task automatic test_back_to_back;
        logic st;
        int n;
        issue(4'd4, 32'd100, 32'd7, st);
        model(4'd4, 32'd100, 32'd7);
        wait_idle(n);
        run_op("b2b", 4'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    endtask

    task automatic test_random;
        logic [3:0] op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 15));
            if (op == 4'd7 || op == 4'd8) op = 4'd1;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_op("rnd", op, a, b);
        end
    endtask

    task automatic test_madd;
`ifdef MD_MADD_EN
        run_op("mthi0", 4'd5, 32'd0, 32'd0);
        run_op("mtlo1", 4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op("maddu", 4'd10, 32'd1, 32'd1);
        n_total++;
        if (m_hi !== 32'd1 || m_lo !== 32'd0) begin
            n_bad++;
            $display("FAIL maddu_model got=%h_%h exp=1_0", m_hi, m_lo);
        end
        run_op("msub", 4'd11, 32'hFFFF_FFFD, 32'd4);
`else
        run_op("op9", 4'd9, 32'd1, 32'd1);
`endif
        run_op("op13", 4'd13, 32'd5, 32'd5);
    endtask

    task automatic test_reset_mid;
        logic st;
        run_op("mthi_pre", 4'd5, 32'h11, 32'd0);
        issue(4'd3, 32'd50, 32'd3, st);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        n_total++;
        if (bus.E_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rmid_busy got=%b exp=0", bus.E_busy);
        end
        bus.E_md_op = 4'd7;
        #1;
        n_total++;
        if (bus.E_HL_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rmid_hi got=%h exp=0", bus.E_HL_data);
        end
        bus.E_md_op = 4'd8;
        #1;
        n_total++;
        if (bus.E_HL_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rmid_lo got=%h exp=0", bus.E_HL_data);
        end
        bus.E_md_op = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 4'd2, 32'd6, 32'd7);
    endtask

    initial begin
        bus.E_md_op = 4'd0;
        bus.E_rs_data = 32'd0;
        bus.E_rt_data = 32'd0;
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_madd();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
